// File: rtl/stage_tl_if.sv
// Shared types and the EX -> TL -> C handshake/bus interface for the translation stage.
package stage_tl_pkg;
    typedef logic [1:0]  threadid_t;
    typedef logic [31:0] vptr_t;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regid_t;
    typedef enum logic [1:0] {
        TLBW_OFF  = 2'd0,
        TLBW_ITLB = 2'd1,
        TLBW_DTLB = 2'd2
    } tlbwrite_t;
endpackage

interface stage_tl_if;
    import stage_tl_pkg::*;

    threadid_t ex_thread;
    logic      ex_isvalid, ex_itlb_miss;
    vptr_t     ex_pc;
    word_t     ex_data, ex_mul, ex_r2;
    regid_t    ex_dst;
    logic      ex_flag_mem, ex_flag_store, ex_flag_isbyte, ex_flag_mul;
    logic      ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret;
    tlbwrite_t ex_flag_tlbwrite;
    logic      c_stall, ex_stall, flush;

    threadid_t c_thread;
    logic      c_isvalid, c_itlb_miss;
    vptr_t     c_pc;
    word_t     c_mul, c_r2, c_addr;
    regid_t    c_dst;
    logic      c_flag_mem, c_flag_store, c_flag_isbyte, c_flag_mul;
    logic      c_flag_reg, c_flag_jump, c_flag_branch, c_flag_iret;
    logic      c_dtlb_miss;

    modport master (
        output ex_thread, ex_isvalid, ex_itlb_miss, ex_pc, ex_data, ex_mul, ex_r2, ex_dst,
               ex_flag_mem, ex_flag_store, ex_flag_isbyte, ex_flag_mul, ex_flag_reg,
               ex_flag_jump, ex_flag_branch, ex_flag_iret, ex_flag_tlbwrite, c_stall, flush,
        input  ex_stall, c_thread, c_isvalid, c_itlb_miss, c_pc, c_mul, c_r2, c_addr, c_dst,
               c_flag_mem, c_flag_store, c_flag_isbyte, c_flag_mul, c_flag_reg,
               c_flag_jump, c_flag_branch, c_flag_iret, c_dtlb_miss
    );

    modport slave (
        input  ex_thread, ex_isvalid, ex_itlb_miss, ex_pc, ex_data, ex_mul, ex_r2, ex_dst,
               ex_flag_mem, ex_flag_store, ex_flag_isbyte, ex_flag_mul, ex_flag_reg,
               ex_flag_jump, ex_flag_branch, ex_flag_iret, ex_flag_tlbwrite, c_stall, flush,
        output ex_stall, c_thread, c_isvalid, c_itlb_miss, c_pc, c_mul, c_r2, c_addr, c_dst,
               c_flag_mem, c_flag_store, c_flag_isbyte, c_flag_mul, c_flag_reg,
               c_flag_jump, c_flag_branch, c_flag_iret, c_dtlb_miss
    );
endinterface

// File: rtl/stage_tl.sv
// TL pipeline stage: fully associative data TLB lookup/write with round-robin replacement,
// registering the EX result into the C stage.
module stage_tl
    import stage_tl_pkg::*;
#(
    parameter int NENTRIES = 4,
    parameter int PPN_W    = 8
) (
    input  logic     clk,
    input  logic     rst,
    stage_tl_if.slave bus
);
    localparam int IDX_W = $clog2(NENTRIES);

    typedef struct packed {
        threadid_t thread;
        logic      isvalid;
        logic      itlb_miss;
        vptr_t     pc;
        word_t     mul;
        word_t     r2;
        regid_t    dst;
        logic      f_mem, f_store, f_isbyte, f_mul, f_reg, f_jump, f_branch, f_iret;
        word_t     addr;
        logic      dtlb_miss;
    } c_t;

    c_t                              c_q, c_d;
    logic [NENTRIES-1:0]             valid_q, valid_d;
    logic [NENTRIES-1:0][19:0]       vpn_q, vpn_d;
    logic [NENTRIES-1:0][PPN_W-1:0]  ppn_q, ppn_d;
    logic [IDX_W-1:0]                ptr_q, ptr_d;

    logic [19:0]       vpn_s;
    logic              hit_s, lookup_s, dtlb_we_s;
    logic [IDX_W-1:0]  hit_idx_s;
    logic [PPN_W-1:0]  hit_ppn_s;

    assign vpn_s     = bus.ex_data[31:12];
    assign hit_ppn_s = ppn_q[hit_idx_s];
    // tlbwrite instructions never translate, so they cannot report a miss
    assign lookup_s  = bus.ex_isvalid & bus.ex_flag_mem & (bus.ex_flag_tlbwrite == TLBW_OFF);
    assign dtlb_we_s = bus.ex_isvalid & (bus.ex_flag_tlbwrite == TLBW_DTLB) & ~bus.c_stall & ~bus.flush;
    assign bus.ex_stall = bus.c_stall;

    // Parallel tag match; entries are kept unique so at most one bit can hit
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (valid_q[i] && (vpn_q[i] == vpn_s)) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // DTLB write: update a matching entry in place, otherwise fill at the pointer
    always_comb begin
        valid_d = valid_q;
        vpn_d   = vpn_q;
        ppn_d   = ppn_q;
        ptr_d   = ptr_q;
        if (dtlb_we_s) begin
            if (hit_s) begin
                ppn_d[hit_idx_s] = bus.ex_r2[PPN_W-1:0];
            end else begin
                valid_d[ptr_q] = 1'b1;
                vpn_d[ptr_q]   = vpn_s;
                ppn_d[ptr_q]   = bus.ex_r2[PPN_W-1:0];
                ptr_d          = ptr_q + IDX_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Next C-stage register contents
    always_comb begin
        c_d = c_q;
        if (!bus.c_stall) begin
            c_d.thread    = bus.ex_thread;
            c_d.isvalid   = bus.ex_isvalid & ~bus.flush;
            c_d.itlb_miss = bus.ex_itlb_miss;
            c_d.pc        = bus.ex_pc;
            c_d.mul       = bus.ex_mul;
            c_d.r2        = bus.ex_r2;
            c_d.dst       = bus.ex_dst;
            c_d.f_mem     = bus.ex_flag_mem;
            c_d.f_store   = bus.ex_flag_store;
            c_d.f_isbyte  = bus.ex_flag_isbyte;
            c_d.f_mul     = bus.ex_flag_mul;
            c_d.f_reg     = bus.ex_flag_reg;
            c_d.f_jump    = bus.ex_flag_jump;
            c_d.f_branch  = bus.ex_flag_branch;
            c_d.f_iret    = bus.ex_flag_iret;
            c_d.addr      = (lookup_s && hit_s) ? word_t'({hit_ppn_s, bus.ex_data[11:0]}) : bus.ex_data;
            c_d.dtlb_miss = lookup_s & ~hit_s;
        end else begin
            c_d = c_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q     <= '0;
            valid_q <= '0;
            vpn_q   <= '0;
            ppn_q   <= '0;
            ptr_q   <= '0;
        end else begin
            c_q     <= c_d;
            valid_q <= valid_d;
            vpn_q   <= vpn_d;
            ppn_q   <= ppn_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.c_thread      = c_q.thread;
    assign bus.c_isvalid     = c_q.isvalid;
    assign bus.c_itlb_miss   = c_q.itlb_miss;
    assign bus.c_pc          = c_q.pc;
    assign bus.c_mul         = c_q.mul;
    assign bus.c_r2          = c_q.r2;
    assign bus.c_dst         = c_q.dst;
    assign bus.c_flag_mem    = c_q.f_mem;
    assign bus.c_flag_store  = c_q.f_store;
    assign bus.c_flag_isbyte = c_q.f_isbyte;
    assign bus.c_flag_mul    = c_q.f_mul;
    assign bus.c_flag_reg    = c_q.f_reg;
    assign bus.c_flag_jump   = c_q.f_jump;
    assign bus.c_flag_branch = c_q.f_branch;
    assign bus.c_flag_iret   = c_q.f_iret;
    assign bus.c_addr        = c_q.addr;
    assign bus.c_dtlb_miss   = c_q.dtlb_miss;
endmodule

// File: tb/tb_stage_tl.sv
// Scoreboard bench for stage_tl: directed vectors push expected C-stage values, a monitor pops and compares.
module tb_stage_tl;
    import stage_tl_pkg::*;

    typedef struct {
        logic   v;
        word_t  addr;
        logic   miss;
        regid_t dst;
        vptr_t  pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    logic mon_en   = 1'b0;
    exp_t q[$];
    exp_t last;
    regid_t dst_cnt = 5'd0;

    stage_tl_if bus ();

    stage_tl #(.NENTRIES(4), .PPN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input word_t act, input word_t req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    function automatic word_t la(input int vpn);
        word_t w;
        w = {vpn[19:0], 12'h010};
        return w;
    endfunction

    function automatic word_t ha(input logic [7:0] ppn);
        word_t w;
        w = {12'h000, ppn, 12'h010};
        return w;
    endfunction

    task automatic idle_inputs();
        bus.ex_thread = 2'd0; bus.ex_isvalid = 1'b0; bus.ex_itlb_miss = 1'b0;
        bus.ex_pc = 32'd0; bus.ex_data = 32'd0; bus.ex_mul = 32'd0; bus.ex_r2 = 32'd0;
        bus.ex_dst = 5'd0; bus.ex_flag_mem = 1'b0; bus.ex_flag_store = 1'b0;
        bus.ex_flag_isbyte = 1'b0; bus.ex_flag_mul = 1'b0; bus.ex_flag_reg = 1'b0;
        bus.ex_flag_jump = 1'b0; bus.ex_flag_branch = 1'b0; bus.ex_flag_iret = 1'b0;
        bus.ex_flag_tlbwrite = TLBW_OFF; bus.c_stall = 1'b0; bus.flush = 1'b0;
    endtask

    // Drive one EX cycle; non-stalled cycles push their expected C-stage result
    task automatic issue(input logic v, input logic mem, input tlbwrite_t tw, input word_t data,
                         input word_t r2, input logic fl, input logic st,
                         input logic ev, input word_t ea, input logic em);
        exp_t e;
        @(negedge clk);
        dst_cnt            = dst_cnt + 5'd1;
        bus.ex_isvalid     = v;
        bus.ex_flag_mem    = mem;
        bus.ex_flag_tlbwrite = tw;
        bus.ex_data        = data;
        bus.ex_r2          = r2;
        bus.ex_dst         = dst_cnt;
        bus.ex_pc          = {25'd0, dst_cnt, 2'b00};
        bus.ex_thread      = dst_cnt[1:0];
        bus.flush          = fl;
        bus.c_stall        = st;
        mon_en             = 1'b1;
        if (!st) begin
            e.v = ev; e.addr = ea; e.miss = em; e.dst = dst_cnt; e.pc = {25'd0, dst_cnt, 2'b00};
            q.push_back(e);
        end
    endtask

    task automatic reset_dut(input logic mid_stall_write);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        q.delete();
        @(negedge clk);
        idle_inputs();
        if (mid_stall_write) begin
            bus.ex_isvalid = 1'b1; bus.ex_flag_tlbwrite = TLBW_DTLB;
            bus.ex_data = la(3); bus.ex_r2 = 32'h5A; bus.c_stall = 1'b1;
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_isvalid", 32'(bus.c_isvalid), 32'd0);
        chk("rst_addr", bus.c_addr, 32'd0);
        chk("rst_miss", 32'(bus.c_dtlb_miss), 32'd0);
        chk("rst_flags", 32'({bus.c_flag_mem, bus.c_flag_store, bus.c_flag_jump, bus.c_flag_iret}), 32'd0);
        chk("rst_ex_stall", 32'(bus.ex_stall), 32'(mid_stall_write));
        rst = 1'b1;
        idle_inputs();
        last = '{1'b0, 32'd0, 1'b0, 5'd0, 32'd0};
    endtask

    // Monitor: compares each captured cycle against the scoreboard head, or against the held value on stalls
    initial begin
        logic st;
        exp_t e;
        forever begin
            @(posedge clk);
            st = bus.c_stall;
            if (rst && mon_en) begin
                #1;
                if (st) begin
                    chk("stall_ex_stall", 32'(bus.ex_stall), 32'd1);
                    chk("stall_hold_addr", bus.c_addr, last.addr);
                    chk("stall_hold_dst", 32'(bus.c_dst), 32'(last.dst));
                    chk("stall_hold_valid", 32'(bus.c_isvalid), 32'(last.v));
                end else if (q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("c_isvalid", 32'(bus.c_isvalid), 32'(e.v));
                    chk("c_addr", bus.c_addr, e.addr);
                    chk("c_dtlb_miss", 32'(bus.c_dtlb_miss), 32'(e.miss));
                    chk("c_dst", 32'(bus.c_dst), 32'(e.dst));
                    chk("c_pc", bus.c_pc, e.pc);
                    last = e;
                end
            end
        end
    end

    initial begin
        idle_inputs();
        reset_dut(1'b0);
        // Miss, write, then hit with one-cycle latency
        issue(1, 1, TLBW_OFF,  la(3), 32'h0,  0, 0, 1, 32'h00003010, 1);
        issue(1, 0, TLBW_DTLB, la(3), 32'h5A, 0, 0, 1, la(3), 0);
        issue(1, 1, TLBW_OFF,  la(3), 32'h0,  0, 0, 1, 32'h0005A010, 0);
        issue(1, 0, TLBW_OFF,  la(3), 32'h0,  0, 0, 1, la(3), 0);
        issue(0, 1, TLBW_OFF,  la(3), 32'h0,  0, 0, 0, la(3), 0);
        // Reset during a stalled write leaves nothing behind
        reset_dut(1'b1);
        issue(1, 1, TLBW_OFF,  la(3), 32'h0,  0, 0, 1, la(3), 1);
        // Fill and evict: VPN 5 replaces VPN 1, pointer ends at 1
        for (int v = 1; v <= 5; v++)
            issue(1, 0, TLBW_DTLB, la(v), 32'(8'h10 + v), 0, 0, 1, la(v), 0);
        for (int v = 2; v <= 5; v++)
            issue(1, 1, TLBW_OFF, la(v), 32'h0, 0, 0, 1, ha(8'(8'h10 + v)), 0);
        issue(1, 1, TLBW_OFF,  la(1), 32'h0,  0, 0, 1, la(1), 1);
        // In-place rewrite of VPN 3; next new VPN lands at entry 1 (evicting VPN 2)
        issue(1, 0, TLBW_DTLB, la(3), 32'h11, 0, 0, 1, la(3), 0);
        issue(1, 0, TLBW_DTLB, la(6), 32'h16, 0, 0, 1, la(6), 0);
        issue(1, 1, TLBW_OFF,  la(3), 32'h0,  0, 0, 1, ha(8'h11), 0);
        issue(1, 1, TLBW_OFF,  la(2), 32'h0,  0, 0, 1, la(2), 1);
        issue(1, 1, TLBW_OFF,  la(4), 32'h0,  0, 0, 1, ha(8'h14), 0);
        issue(1, 1, TLBW_OFF,  la(6), 32'h0,  0, 0, 1, ha(8'h16), 0);
        issue(1, 1, TLBW_OFF,  la(5), 32'h0,  0, 0, 1, ha(8'h15), 0);
        // Three stalled cycles with changing inputs, including a write that must not land
        issue(1, 0, TLBW_DTLB, la(9), 32'h99, 0, 1, 0, 32'h0, 0);
        issue(1, 1, TLBW_OFF,  la(4), 32'h0,  0, 1, 0, 32'h0, 0);
        issue(1, 0, TLBW_OFF,  32'hDEADBEEF, 32'h0, 0, 1, 0, 32'h0, 0);
        issue(1, 1, TLBW_OFF,  la(9), 32'h0,  0, 0, 1, la(9), 1);
        // Flush kills validity but still translates
        issue(1, 1, TLBW_OFF,  la(4), 32'h0,  1, 0, 0, ha(8'h14), 0);
        // Write visible only from the following cycle
        issue(1, 1, TLBW_OFF,  la(7), 32'h0,  0, 0, 1, la(7), 1);
        issue(1, 0, TLBW_DTLB, la(7), 32'h77, 0, 0, 1, la(7), 0);
        issue(1, 1, TLBW_OFF,  la(7), 32'h0,  0, 0, 1, ha(8'h77), 0);
        // Flushed write and ITLB write leave the DTLB alone
        issue(1, 0, TLBW_DTLB, la(10), 32'hAA, 1, 0, 0, la(10), 0);
        issue(1, 1, TLBW_OFF,  la(10), 32'h0,  0, 0, 1, la(10), 1);
        issue(1, 0, TLBW_ITLB, la(11), 32'hBB, 0, 0, 1, la(11), 0);
        issue(1, 1, TLBW_OFF,  la(11), 32'h0,  0, 0, 1, la(11), 1);
        // tlbwrite flagged as memory op: no lookup, no miss
        issue(1, 1, TLBW_DTLB, la(12), 32'hCC, 0, 0, 1, la(12), 0);
        issue(0, 0, TLBW_OFF,  32'h0,  32'h0,  0, 0, 0, 32'h0, 0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/stage_tl.md
STAGE_TL -- requirements
Module: stage_tl

Interface
REQ-001 Parameter: NENTRIES, default 4, number of fully associative DTLB entries (power of two, 2..16).
REQ-002 Parameter: PPN_W, default 8, physical page number width; page size fixed at 4 KiB, VPN = addr[31:12].
REQ-003 Ports, clock and reset first: clk  in  1  sole clock; rst  in  1  asynchronous, active-low reset.
REQ-004 Port: ex_thread  in  threadid_t  thread of incoming EX result.
REQ-005 Port: ex_isvalid, ex_itlb_miss  in  1 each  valid and fetch-miss flags from EX.
REQ-006 Port: ex_pc  in  vptr_t  instruction PC.
REQ-007 Port: ex_data, ex_mul, ex_r2  in  word_t each  ALU result/address, multiplier product, store data.
REQ-008 Port: ex_dst  in  regid_t  destination register.
REQ-009 Port: ex_flag_mem, _store, _isbyte, _mul, _reg, _jump, _branch, _iret  in  1 each  control flags.
REQ-010 Port: ex_flag_tlbwrite  in  tlbwrite_t  off/itlb/dtlb write request.
REQ-011 Port: c_stall  in  1  downstream cache stage cannot accept; ex_stall  out  1  hold request to EX.
REQ-012 Port: flush  in  1  kill instruction currently entering the TL register.
REQ-013 Port: c_* outputs  out  same widths as ex_* counterparts  registered copies of every ex_* field except ex_data and ex_flag_tlbwrite.
REQ-014 Port: c_addr  out  word_t  ex_data for non-memory ops; {PPN, ex_data[11:0]} zero-extended for memory ops on hit.
REQ-015 Port: c_dtlb_miss  out  1  registered data-TLB miss flag.

Function
REQ-016 DTLB entry: valid bit, 20-bit VPN, PPN_W-bit PPN; lookup compares ex_data[31:12] against all valid entries in parallel.
REQ-017 Hit, ex_isvalid=1 and ex_flag_mem=1: next c_addr = {zeros, PPN, ex_data[11:0]}, c_dtlb_miss=0.
REQ-018 Miss, ex_isvalid=1 and ex_flag_mem=1: c_addr = ex_data unchanged, c_dtlb_miss=1, c_isvalid unchanged; instruction proceeds for exception at WB.
REQ-019 Non-memory or invalid instruction: c_addr = ex_data, c_dtlb_miss=0, no lookup side effects.
REQ-020 Latency: one cycle; all c_* outputs registered, updated on posedge clk when c_stall=0.
REQ-021 c_stall=1: all c_* registers, DTLB contents and replacement pointer hold; ex_stall = c_stall, combinational.
REQ-022 flush=1 and c_stall=0: c_isvalid loads 0; other c_* fields load normally; no DTLB write.
REQ-023 DTLB write: ex_isvalid=1, ex_flag_tlbwrite=dtlb, c_stall=0, flush=0; VPN = ex_data[31:12], PPN = ex_r2[PPN_W-1:0].
REQ-024 Write VPN matches a valid entry: overwrite that entry's PPN; pointer unchanged; duplicates never created.
REQ-025 Otherwise: write into entry at round-robin pointer, set valid, pointer increments modulo NENTRIES, wrapping NENTRIES-1 -> 0.
REQ-026 Replacement ignores valid bits; invalid entries are not preferentially filled.
REQ-027 Write and lookup in the same cycle: lookup sees pre-write contents; write is visible from the next cycle.
REQ-028 ex_flag_tlbwrite=itlb: no DTLB effect; instruction passes through.
REQ-029 A tlbwrite instruction never performs a lookup; c_dtlb_miss=0 for it.

Reset
REQ-030 rst low asynchronously clears all c_* outputs, c_flag_* and c_dtlb_miss to 0, all DTLB valid bits to 0, replacement pointer to 0.
REQ-031 Reset asserted mid-stall or mid-write: no partial entry survives; first post-reset lookup misses.
REQ-032 ex_stall after reset equals c_stall; no internal stall source.

Verification
REQ-033 Reset, then load at ex_data=0x00003010 -> c_dtlb_miss=1, c_addr=0x00003010.
REQ-034 dtlb write VPN 0x00003, ex_r2=0x5A, then same load -> c_addr=0x0005A010, c_dtlb_miss=0, one cycle latency.
REQ-035 Five writes with distinct VPNs 1..5, NENTRIES=4 -> VPN 1 evicted, pointer=1; lookups of VPNs 2..5 hit, VPN 1 misses.
REQ-036 Rewrite VPN 3 with PPN 0x11 -> single entry updated, pointer unchanged, lookup returns PPN 0x11.
REQ-037 c_stall=1 for 3 cycles with changing ex_* -> c_* frozen, pending write not applied until release.
REQ-038 flush=1 with valid load -> c_isvalid=0; write and lookup of VPN 7 in the same cycle -> lookup misses, next-cycle lookup hits.
